// File: rtl/stack_prog_loader_pkg.sv
// +--------------------------------------------------------------------+
// | stack_prog_loader_pkg: shared opcodes, sizes and FSM state encoding |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package stack_prog_loader_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int ADDR_W     = 5;
  localparam int WORD_W     = 12;

  localparam logic [3:0] OP_PUSHC = 4'd0;
  localparam logic [3:0] OP_DUP   = 4'd1;
  localparam logic [3:0] OP_DROP  = 4'd2;
  localparam logic [3:0] OP_SWAP  = 4'd3;
  localparam logic [3:0] OP_JMP   = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stack_prog_loader_if.sv
// +--------------------------------------------------------------------+
// | stack_prog_loader_if: byte stream in, instruction-memory port out   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface stack_prog_loader_if;
  import stack_prog_loader_pkg::*;

  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                im_we;
  logic [ADDR_W-1:0]   im_addr;
  logic [WORD_W-1:0]   im_wdata;
  logic                cpu_rstN;
  logic                done;
  logic                err;

  // slave: the loader itself
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata, cpu_rstN, done, err
  );

  // master: byte source / memory / CPU side
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata, cpu_rstN, done, err
  );

endinterface

`default_nettype wire

// File: rtl/stack_prog_loader.sv
// +--------------------------------------------------------------------+
// | stack_prog_loader: framed byte loader for the stack-machine IMEM    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module stack_prog_loader
  import stack_prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = stack_prog_loader_pkg::IMEM_DEPTH,
  parameter int MAX_OP     = 7
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stack_prog_loader_if.slave bus
);

  localparam logic [7:0] C_MAX_N  = 8'(IMEM_DEPTH);
  localparam logic [3:0] C_MAX_OP = 4'(MAX_OP);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic [7:0]        r_csum;
  logic [3:0]        r_op;
  logic [7:0]        r_val;

  logic w_ready;
  logic w_xfer;
  logic w_count_ok;
  logic w_hi_ok;
  logic w_reload;

  assign w_ready    = (r_state != S_WRITE);
  assign w_xfer     = bus.rx_valid & w_ready;
  assign w_count_ok = (bus.rx_data != 8'd0) && (bus.rx_data <= C_MAX_N);
  assign w_hi_ok    = (bus.rx_data[7:4] == 4'd0) && (bus.rx_data[3:0] <= C_MAX_OP);
  // DONE and ERR behave like IDLE: any accepted byte starts a new frame
  assign w_reload   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_xfer) w_next = w_count_ok ? S_HI : S_ERR;
      end
      S_HI: begin
        if (w_xfer) w_next = w_hi_ok ? S_LO : S_ERR;
      end
      S_LO: begin
        if (w_xfer) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (r_idx == r_last) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (w_xfer) w_next = (bus.rx_data == r_csum) ? S_DONE : S_ERR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // r_last holds N-1; the 5-bit subtract maps N=32 onto index 31
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_last <= '0;
      r_csum <= 8'd0;
      r_op   <= 4'd0;
      r_val  <= 8'd0;
    end else if (w_reload) begin
      if (w_xfer && w_count_ok) begin
        r_idx  <= '0;
        r_last <= bus.rx_data[ADDR_W-1:0] - 5'd1;
        r_csum <= bus.rx_data;
      end
    end else if (r_state == S_HI) begin
      if (w_xfer && w_hi_ok) begin
        r_op   <= bus.rx_data[3:0];
        r_csum <= r_csum ^ bus.rx_data;
      end
    end else if (r_state == S_LO) begin
      if (w_xfer) begin
        r_val  <= bus.rx_data;
        r_csum <= r_csum ^ bus.rx_data;
      end
    end else if (r_state == S_WRITE) begin
      r_idx <= r_idx + 5'd1;
    end
  end

  assign bus.rx_ready = w_ready;
  assign bus.im_we    = (r_state == S_WRITE);
  assign bus.im_addr  = r_idx;
  assign bus.im_wdata = {r_op, r_val};
  assign bus.cpu_rstN = (r_state == S_DONE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_stack_prog_loader.sv
// +--------------------------------------------------------------------+
// | tb_stack_prog_loader: directed self-checking bench for the loader   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_stack_prog_loader;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  stack_prog_loader_if bus ();

  stack_prog_loader #(.IMEM_DEPTH(32), .MAX_OP(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory model and write log, sampled mid-cycle
  logic [11:0] mem [32];
  logic [4:0]  wr_log [256];
  int          wr_count = 0;
  int          rdy_bad  = 0;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      mem[bus.im_addr]       <= bus.im_wdata;
      wr_log[wr_count[7:0]]  <= bus.im_addr;
      wr_count               <= wr_count + 1;
    end
    if (bus.rx_ready !== ~bus.im_we) rdy_bad <= rdy_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $error("FAIL send_timeout observed=%0h expected=1", bus.rx_ready);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int          base;
    int          bad_addr;
    int          bad_data;
    logic [7:0]  csum;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp_w [32];

    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rx_ready", bus.rx_ready, 1);
    chk("rst_im_we",    bus.im_we,    0);
    chk("rst_im_addr",  bus.im_addr,  0);
    chk("rst_im_wdata", bus.im_wdata, 0);
    chk("rst_done",     bus.done,     0);
    chk("rst_err",      bus.err,      0);
    chk("rst_cpu_rstN", bus.cpu_rstN, 0);
    rst = 1'b0;

    // good two-word frame, checksum 02^00^05^06^00 = 01
    base = wr_count;
    send(8'h02, 0); send(8'h00, 0); send(8'h05, 0); send(8'h06, 0);
    chk("a_cpu_rstN_loading", bus.cpu_rstN, 0);
    send(8'h00, 0); send(8'h01, 0);
    idle(1);
    chk("a_done",     bus.done,        1);
    chk("a_err",      bus.err,         0);
    chk("a_cpu_rstN", bus.cpu_rstN,    1);
    chk("a_writes",   wr_count - base, 2);
    chk("a_addr0",    wr_log[base[7:0]],       0);
    chk("a_addr1",    wr_log[8'(base + 1)],    1);
    chk("a_mem0",     mem[0], 12'h005);
    chk("a_mem1",     mem[1], 12'h600);

    // reload from DONE with bad checksum
    base = wr_count;
    send(8'h02, 0);
    chk("b_done_cleared", bus.done, 0);
    send(8'h00, 1); send(8'h05, 0); send(8'h06, 2); send(8'h00, 0); send(8'h00, 0);
    idle(1);
    chk("b_err",      bus.err,         1);
    chk("b_done",     bus.done,        0);
    chk("b_cpu_rstN", bus.cpu_rstN,    0);
    chk("b_writes",   wr_count - base, 2);

    // illegal counts 0 and 33
    do_reset();
    base = wr_count;
    send(8'h00, 0);
    idle(1);
    chk("c0_err", bus.err, 1);
    do_reset();
    send(8'h21, 0);
    idle(1);
    chk("c33_err",   bus.err,         1);
    chk("c_writes",  wr_count - base, 0);

    // illegal hi bytes
    do_reset();
    base = wr_count;
    send(8'h01, 0); send(8'h08, 0);
    idle(2);
    chk("h08_err", bus.err, 1);
    do_reset();
    send(8'h01, 0); send(8'h15, 0);
    idle(2);
    chk("h15_err",   bus.err,         1);
    chk("h15_done",  bus.done,        0);
    chk("h_writes",  wr_count - base, 0);

    // full 32-word frame with random valid gaps
    do_reset();
    base = wr_count;
    csum = 8'h20;
    send(8'h20, $urandom_range(0, 2));
    for (int i = 0; i < 32; i++) begin
      hi = 8'(i % 8);
      lo = 8'(i * 7 + 3);
      exp_w[i] = {hi[3:0], lo};
      csum = csum ^ hi ^ lo;
      send(hi, $urandom_range(0, 2));
      send(lo, $urandom_range(0, 2));
    end
    send(csum, $urandom_range(0, 2));
    idle(2);
    bad_addr = 0;
    bad_data = 0;
    for (int i = 0; i < 32; i++) begin
      if (wr_log[8'(base + i)] !== 5'(i)) bad_addr++;
      if (mem[i] !== exp_w[i]) bad_data++;
    end
    chk("f32_writes",   wr_count - base, 32);
    chk("f32_addr_ord", bad_addr, 0);
    chk("f32_data",     bad_data, 0);
    chk("f32_done",     bus.done, 1);

    // reset after 3 words of a 5-word frame, reset also coincides with a byte
    base = wr_count;
    send(8'h05, 0);
    for (int i = 0; i < 3; i++) begin
      send(8'h01, 0);
      send(8'h10, 0);
    end
    idle(2);
    chk("r_pre_writes", wr_count - base, 3);
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h01;
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    chk("r_done",  bus.done,  0);
    chk("r_err",   bus.err,   0);
    chk("r_im_we", bus.im_we, 0);
    idle(5);
    chk("r_no_more_writes", wr_count - base, 3);
    chk("r_mem1_kept", mem[1], 12'h110);
    // fresh frame 01,03,0A, checksum 01^03^0A = 08
    send(8'h01, 0); send(8'h03, 0); send(8'h0A, 0); send(8'h08, 0);
    idle(1);
    chk("r_new_writes", wr_count - base, 4);
    chk("r_new_addr",   wr_log[8'(base + 3)], 0);
    chk("r_new_data",   mem[0], 12'h30A);
    chk("r_new_done",   bus.done, 1);

    chk("ready_only_low_in_write", rdy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_prog_loader.md
STACK_PROG_LOADER -- requirements
Module: stack_prog_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 32, instruction memory words; address width 5.
REQ-002 Parameter MAX_OP, default 7, highest legal opcode.
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rx_valid  input  1  upstream byte valid.
REQ-006 rx_data  input  8  upstream byte.
REQ-007 rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid and rx_ready are both high.
REQ-008 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 im_addr  output  5  write address.
REQ-010 im_wdata  output  12  instruction word; [11:8] opcode, [7:0] value.
REQ-011 cpu_rstN  output  1  active-low reset to the downstream stack machine; low while loading.
REQ-012 done  output  1  program loaded and checksum good; level.
REQ-013 err  output  1  load failed; level.

Function
REQ-014 Frame format: count byte N, then N word pairs (hi byte, lo byte), then one checksum byte.
REQ-015 Legal N is 1..32; N=0 or N>32 on the count byte goes to ERR.
REQ-016 Hi byte: [3:0] is the opcode; [7:4] must be 0 and the opcode must be <= MAX_OP, otherwise ERR.
REQ-017 Lo byte: the value; acceptance completes the word.
REQ-018 Checksum: XOR of the count byte and all 2N word bytes; the checksum byte must equal it, otherwise ERR.
REQ-019 States: IDLE, HI, LO, WRITE, CHK, DONE, ERR.
REQ-020 IDLE: accept count; legal -> HI, word index cleared, checksum seeded with count.
REQ-021 HI: accept byte; legal -> LO, opcode latched; illegal -> ERR.
REQ-022 LO: accept byte -> WRITE.
REQ-023 WRITE: one cycle; im_we=1, im_addr=index, im_wdata={opcode,value}; rx_ready=0.
REQ-024 WRITE exit: index increments; -> CHK if index was N-1, else -> HI.
REQ-025 CHK: accept byte; match -> DONE, mismatch -> ERR.
REQ-026 DONE: done=1 and cpu_rstN=1.
REQ-027 ERR: err=1 and cpu_rstN=0.
REQ-028 DONE or ERR accepting a byte treats it as a new count byte, with the same decision as IDLE.
REQ-029 On a reload from DONE/ERR, done and err clear in the cycle after the count byte is accepted.
REQ-030 rx_ready=1 in every state except WRITE.
REQ-031 Bytes are consumed only on handshake; rx_valid low stalls any state indefinitely with no state change.
REQ-032 im_we is registered, asserting the cycle after the lo byte is accepted; latency lo-byte to write is 1 cycle.
REQ-033 cpu_rstN=0 in IDLE, HI, LO, WRITE, CHK, ERR.
REQ-034 Words at addresses >= N are not written and keep their prior contents.
REQ-035 done and err are never high simultaneously.

Reset
REQ-036 rst high forces IDLE, index 0, checksum 0, opcode latch 0, im_we=0, im_addr=0, im_wdata=0, done=0, err=0, cpu_rstN=0, rx_ready=1.
REQ-037 rst mid-frame abandons the frame; no further im_we until a new frame; memory already written is not cleared.
REQ-038 rst has priority over a simultaneous handshake; the byte is dropped.

Structure
REQ-039 A shared package holds the opcode constants (pushc=0 .. sub=7), IMEM_DEPTH, and the state encoding.
REQ-040 The module is a single FSM with no sub-module; the checksum is an inline XOR register.

Verification
REQ-041 Frame 02,00,05,06,00,xx with xx the correct checksum 01 -> writes addr0=0x005 and addr1=0x600, then done=1, cpu_rstN=1.
REQ-042 Same frame with checksum 00 -> two writes, then err=1, done=0, cpu_rstN=0.
REQ-043 Count byte 00, then separately 21 -> ERR after each, no im_we.
REQ-044 Hi byte 08 or 15 -> ERR immediately, no write for that word.
REQ-045 rx_valid toggled randomly across a 32-word frame -> exactly 32 writes, addresses 0..31 in order, rx_ready low only in WRITE cycles.
REQ-046 rst pulsed after 3 words of a 5-word frame, then a fresh 1-word frame -> state IDLE, first write of the new frame at addr0, done=1.
